fp_adder_seq: RTL and testbench



---
 rtl/fp_adder_pkg.sv | 28 ++
 rtl/fp_unpack.sv | 41 ++++
 rtl/fp_adder_seq.sv | 204 ++++++++++++++++++++
 tb/tb_fp_adder_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fp_adder_pkg.sv
// Shared definitions for the sequential floating-point adder:
// FSM encoding, operand class codes and format helpers.
package fp_adder_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_ALIGN = 3'd1;
   localparam state_t S_ADD   = 3'd2;
   localparam state_t S_NORM  = 3'd3;
   localparam state_t S_ROUND = 3'd4;
   localparam state_t S_DONE  = 3'd5;

   localparam logic [1:0] CLS_ZERO   = 2'd0;
   localparam logic [1:0] CLS_NORMAL = 2'd1;
   localparam logic [1:0] CLS_INF    = 2'd2;
   localparam logic [1:0] CLS_NAN    = 2'd3;

   function automatic int bias_of(input int exp_w);
      return (32'sd1 <<< (exp_w - 1)) - 32'sd1;
   endfunction

   // carry, hidden, fraction, guard, round, sticky
   function automatic int wm_width(input int man_w);
      return man_w + 5;
   endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits a packed float into sign, exponent and mantissa with hidden bit,
// and classifies it; denormals are reported as zero.
module fp_unpack
   import fp_adder_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
)
(
   input  logic [EXP_W+MAN_W:0] word,
   output logic                 sign,
   output logic [EXP_W-1:0]     exponent,
   output logic [MAN_W:0]       mantissa,
   output logic [1:0]           cls
);

   logic [EXP_W-1:0] exp_f_s;
   logic [MAN_W-1:0] frac_s;

   assign sign     = word[EXP_W+MAN_W];
   assign exp_f_s  = word[EXP_W+MAN_W-1:MAN_W];
   assign frac_s   = word[MAN_W-1:0];
   assign exponent = exp_f_s;

   // classify and attach hidden bit
   always_comb begin
      cls      = CLS_NORMAL;
      mantissa = {1'b1, frac_s};
      if (exp_f_s == {EXP_W{1'b0}}) begin
         cls      = CLS_ZERO;
         mantissa = {(MAN_W+1){1'b0}};
      end else if (exp_f_s == {EXP_W{1'b1}}) begin
         cls      = (frac_s == {MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
         mantissa = {1'b1, frac_s};
      end else begin
         cls      = CLS_NORMAL;
         mantissa = {1'b1, frac_s};
      end
   end

endmodule

// File: rtl/fp_adder_seq.sv
// Sequential floating-point adder/subtractor with valid/ready handshakes,
// iterative normalisation and round-to-nearest-even.
module fp_adder_seq
   import fp_adder_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op,
   input  logic [EXP_W+MAN_W:0] A,
   input  logic [EXP_W+MAN_W:0] B,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] Sum,
   output logic                 Cout,
   output logic                 Overflow
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int WM = wm_width(MAN_W);
   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   logic             sa_s, sb_raw_s, sb_eff_s;
   logic [EXP_W-1:0] ea_s, eb_s;
   logic [MAN_W:0]   ma_s, mb_s;
   logic [1:0]       ca_s, cb_s;

   state_t           state_r;
   logic             sign_a_r, sign_b_r;
   logic [EXP_W:0]   exp_a_r;
   logic [EXP_W-1:0] exp_b_r;
   logic [WM-1:0]    man_a_r, man_b_r;
   logic             out_valid_r, cout_r, overflow_r;
   logic [W-1:0]     sum_r;

   logic             bypass_s;
   logic [W-1:0]     byp_sum_s;
   logic             a_ge_b_s, big_sign_s, sml_sign_s;
   logic [EXP_W-1:0] big_exp_s, sml_exp_s, diff_s;
   logic [WM-1:0]    big_man_s, sml_man_s, shift_mask_s, aligned_s;
   logic             rnd_up_s, rnd_ovf_s;
   logic [MAN_W+1:0] rnd_man_s;
   logic [EXP_W:0]   rnd_exp_s;

   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
      .word(A), .sign(sa_s), .exponent(ea_s), .mantissa(ma_s), .cls(ca_s)
   );
   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
      .word(B), .sign(sb_raw_s), .exponent(eb_s), .mantissa(mb_s), .cls(cb_s)
   );

   assign sb_eff_s  = sb_raw_s ^ op;
   assign in_ready  = (state_r == S_IDLE) && !rst;
   assign out_valid = out_valid_r;
   assign Sum       = sum_r;
   assign Cout      = cout_r;
   assign Overflow  = overflow_r;

   // special-operand results that skip the arithmetic pipeline
   always_comb begin
      bypass_s  = 1'b1;
      byp_sum_s = QNAN;
      if (ca_s == CLS_NAN || cb_s == CLS_NAN) begin
         byp_sum_s = QNAN;
      end else if (ca_s == CLS_INF && cb_s == CLS_INF) begin
         byp_sum_s = (sa_s != sb_eff_s) ? QNAN : {sa_s, EXP_ONES, {MAN_W{1'b0}}};
      end else if (ca_s == CLS_INF) begin
         byp_sum_s = {sa_s, EXP_ONES, {MAN_W{1'b0}}};
      end else if (cb_s == CLS_INF) begin
         byp_sum_s = {sb_eff_s, EXP_ONES, {MAN_W{1'b0}}};
      end else if (ca_s == CLS_ZERO && cb_s == CLS_ZERO) begin
         byp_sum_s = {sa_s & sb_eff_s, {(W-1){1'b0}}};
      end else begin
         bypass_s = 1'b0;
      end
   end

   // magnitude swap and sticky-preserving alignment shift
   always_comb begin
      a_ge_b_s = {exp_a_r[EXP_W-1:0], man_a_r} >= {exp_b_r, man_b_r};
      if (a_ge_b_s) begin
         big_sign_s = sign_a_r;  big_exp_s = exp_a_r[EXP_W-1:0];  big_man_s = man_a_r;
         sml_sign_s = sign_b_r;  sml_exp_s = exp_b_r;             sml_man_s = man_b_r;
      end else begin
         big_sign_s = sign_b_r;  big_exp_s = exp_b_r;             big_man_s = man_b_r;
         sml_sign_s = sign_a_r;  sml_exp_s = exp_a_r[EXP_W-1:0];  sml_man_s = man_a_r;
      end
      diff_s       = big_exp_s - sml_exp_s;
      shift_mask_s = ~({WM{1'b1}} << diff_s);
      if (32'(diff_s) >= 32'(MAN_W + 3)) begin
         aligned_s = {{(WM-1){1'b0}}, |sml_man_s};
      end else begin
         aligned_s    = sml_man_s >> diff_s;
         aligned_s[0] = aligned_s[0] | (|(sml_man_s & shift_mask_s));
      end
   end

   // round-to-nearest-even on the normalised working mantissa
   always_comb begin
      rnd_up_s  = man_a_r[2] & (man_a_r[1] | man_a_r[0] | man_a_r[3]);
      rnd_man_s = {1'b0, man_a_r[WM-2:3]} + {{(MAN_W+1){1'b0}}, rnd_up_s};
      rnd_exp_s = exp_a_r + {{EXP_W{1'b0}}, rnd_man_s[MAN_W+1]};
      rnd_ovf_s = rnd_exp_s >= {1'b0, EXP_ONES};
   end

   // control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         out_valid_r <= 1'b0;
         sum_r       <= {W{1'b0}};
         cout_r      <= 1'b0;
         overflow_r  <= 1'b0;
         sign_a_r    <= 1'b0;
         sign_b_r    <= 1'b0;
         exp_a_r     <= {(EXP_W+1){1'b0}};
         exp_b_r     <= {EXP_W{1'b0}};
         man_a_r     <= {WM{1'b0}};
         man_b_r     <= {WM{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               if (in_valid) begin
                  cout_r     <= 1'b0;
                  overflow_r <= 1'b0;
                  sign_a_r   <= sa_s;
                  sign_b_r   <= sb_eff_s;
                  exp_a_r    <= {1'b0, ea_s};
                  exp_b_r    <= eb_s;
                  man_a_r    <= {1'b0, ma_s, 3'b000};
                  man_b_r    <= {1'b0, mb_s, 3'b000};
                  if (bypass_s) begin
                     sum_r       <= byp_sum_s;
                     out_valid_r <= 1'b1;
                     state_r     <= S_DONE;
                  end else begin
                     state_r <= S_ALIGN;
                  end
               end
            end
            S_ALIGN: begin
               sign_a_r <= big_sign_s;
               sign_b_r <= sml_sign_s;
               exp_a_r  <= {1'b0, big_exp_s};
               man_a_r  <= big_man_s;
               man_b_r  <= aligned_s;
               state_r  <= S_ADD;
            end
            S_ADD: begin
               man_a_r <= (sign_a_r ^ sign_b_r) ? (man_a_r - man_b_r) : (man_a_r + man_b_r);
               state_r <= S_NORM;
            end
            S_NORM: begin
               if (man_a_r == {WM{1'b0}}) begin
                  sum_r       <= {W{1'b0}};
                  out_valid_r <= 1'b1;
                  state_r     <= S_DONE;
               end else if (man_a_r[WM-1]) begin
                  man_a_r <= {1'b0, man_a_r[WM-1:2], man_a_r[1] | man_a_r[0]};
                  exp_a_r <= exp_a_r + {{EXP_W{1'b0}}, 1'b1};
                  cout_r  <= 1'b1;
                  state_r <= S_ROUND;
               end else if (man_a_r[WM-2]) begin
                  state_r <= S_ROUND;
               end else if (exp_a_r <= {{EXP_W{1'b0}}, 1'b1}) begin
                  sum_r       <= {sign_a_r, {(W-1){1'b0}}};
                  out_valid_r <= 1'b1;
                  state_r     <= S_DONE;
               end else begin
                  man_a_r <= man_a_r << 1;
                  exp_a_r <= exp_a_r - {{EXP_W{1'b0}}, 1'b1};
               end
            end
            S_ROUND: begin
               if (rnd_ovf_s) begin
                  sum_r      <= {sign_a_r, EXP_ONES, {MAN_W{1'b0}}};
                  overflow_r <= 1'b1;
               end else begin
                  sum_r <= {sign_a_r, rnd_exp_s[EXP_W-1:0], rnd_man_s[MAN_W-1:0]};
               end
               out_valid_r <= 1'b1;
               state_r     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= S_IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_adder_seq.sv
// Directed self-checking bench for fp_adder_seq: single precision plus a
// half-precision instance.
module tb_fp_adder_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, op, out_valid, out_ready, cout, ovf;
   logic [31:0] a_in, b_in, sum;

   logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready, h_cout, h_ovf;
   logic [15:0] h_a, h_b, h_sum;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fp_adder_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .A(a_in), .B(b_in), .out_valid(out_valid), .out_ready(out_ready),
      .Sum(sum), .Cout(cout), .Overflow(ovf)
   );

   fp_adder_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
      .A(h_a), .B(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
      .Sum(h_sum), .Cout(h_cout), .Overflow(h_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp_v);
      end
   endtask

   task automatic start_op(input logic o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; a_in = a; b_in = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // latency counted in edges, the capture edge being 1
   task automatic wait_valid(input string tag, output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
   endtask

   task automatic consume(input string tag);
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, ".drop"}, 32'(out_valid), 32'd0);
   endtask

   task automatic run_vec(input string tag, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_sum,
                          input logic exp_c, input logic exp_v, input int exp_lat);
      int lat;
      start_op(o, a, b);
      wait_valid(tag, lat);
      check({tag, ".sum"}, sum, exp_sum);
      check({tag, ".cout"}, 32'(cout), 32'(exp_c));
      check({tag, ".ovf"}, 32'(ovf), 32'(exp_v));
      if (exp_lat > 0) check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      consume(tag);
   endtask

   initial begin
      int lat;
      int bad;
      logic [31:0] held;
      rst = 1'b1; in_valid = 1'b0; op = 1'b0; a_in = 32'h0; b_in = 32'h0; out_ready = 1'b0;
      h_in_valid = 1'b0; h_op = 1'b0; h_a = 16'h0; h_b = 16'h0; h_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.sum", sum, 32'h0);
      check("rst.cout", 32'(cout), 32'd0);
      check("rst.ovf", 32'(ovf), 32'd0);
      check("rst.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk) rst = 1'b0;
      #1 check("idle.in_ready", 32'(in_ready), 32'd1);

      run_vec("add1",      1'b0, 32'h3E99999A, 32'h43FA2000, 32'h43FA4666, 1'b0, 1'b0, 5);
      run_vec("add_neg",   1'b0, 32'hBE99999A, 32'h43FA2000, 32'h43F9F99A, 1'b0, 1'b0, 5);
      run_vec("add_2neg",  1'b0, 32'hC04C28F6, 32'hC103851F, 32'hC1368F5C, 1'b0, 1'b0, 5);
      run_vec("sub_ulp",   1'b1, 32'h3F800001, 32'h3F800000, 32'h34000000, 1'b0, 1'b0, 28);
      run_vec("sub_eq",    1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 0);
      run_vec("sub_k1",    1'b1, 32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 6);
      run_vec("ovf",       1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b1, 5);
      run_vec("one_one",   1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1, 1'b0, 5);
      run_vec("rne_even",  1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0, 5);
      run_vec("rne_odd",   1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0, 5);
      run_vec("rnd_renrm", 1'b0, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 1'b0, 1'b0, 5);
      run_vec("inf_ninf",  1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0, 1);
      run_vec("fin_sub_inf", 1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 1);
      run_vec("nan",       1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1);
      run_vec("neg_zero",  1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1);
      run_vec("denorm",    1'b0, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);

      // result held while the consumer stalls
      start_op(1'b0, 32'h3E99999A, 32'h43FA2000);
      wait_valid("hold", lat);
      held = sum;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (sum !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      check("hold.stable", 32'(bad), 32'd0);
      check("hold.sum", held, 32'h43FA4666);
      consume("hold");

      // reset in the middle of normalisation
      start_op(1'b1, 32'h3F800001, 32'h3F800000);
      repeat (6) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_norm.out_valid", 32'(out_valid), 32'd0);
      check("rst_norm.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk) rst = 1'b0;
      #1 check("rst_norm.idle", 32'(in_ready), 32'd1);
      run_vec("after_rst", 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1, 1'b0, 5);

      // reset drops a pending result
      start_op(1'b0, 32'h3F800000, 32'h40000000);
      wait_valid("rst_done", lat);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 check("rst_done.out_valid", 32'(out_valid), 32'd0);
      @(negedge clk) rst = 1'b0;

      // half-precision instance: 1.0 + 2.0
      @(negedge clk);
      h_a = 16'h3C00; h_b = 16'h4000; h_in_valid = 1'b1;
      @(posedge clk);
      #1 h_in_valid = 1'b0;
      lat = 1;
      while (!h_out_valid && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
      check("half.valid", 32'(h_out_valid), 32'd1);
      check("half.sum", 32'(h_sum), 32'h00004200);
      check("half.lat", 32'(lat), 32'd5);
      check("half.cout", 32'(h_cout), 32'd0);
      @(negedge clk) h_out_ready = 1'b1;
      @(posedge clk);
      #1 h_out_ready = 1'b0;
      check("half.drop", 32'(h_out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
